// File: rtl/shift_seq_pkg.sv
// Shared widths and FSM state type for the shift sequencer.
// Optional self-check is enabled by defining SHIFT_SEQ_CHECK_EN.
package shift_seq_pkg;

    localparam int DATA_W  = 8;
    localparam int SHAMT_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/shift_seq_model.sv
// Reference value of the downstream shifter after a load and shamt shifts.
// Only instantiated when SHIFT_SEQ_CHECK_EN is defined.
module shift_seq_model
    import shift_seq_pkg::*;
(
    input  logic [DATA_W-1:0]  val_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               arith_i,
    output logic [DATA_W-1:0]  exp_o
);

    // Separate statements keep the signed operand self-contained for >>>
    always_comb begin
        exp_o = val_i >> shamt_i;
        if (arith_i) begin
            exp_o = $signed(val_i) >>> shamt_i;
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Sequences load/shift/capture on an external 8-bit shifter.
// Define SHIFT_SEQ_CHECK_EN to compare the captured value against a model.
module shift_sequencer
    import shift_seq_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [DATA_W-1:0]  load_val,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    input  logic [DATA_W-1:0]  shift_in,
    output logic               load_n,
    output logic               shift_right,
    output logic               asr,
    output logic               busy,
    output logic               done,
    output logic [DATA_W-1:0]  result,
    output logic               mismatch
);

    state_t             state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [SHAMT_W-1:0] shamt_q;
    logic               arith_q;
    logic [DATA_W-1:0]  result_q;
    logic               accept;

    assign accept = (state_q == IDLE) && start;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        load_n      = 1'b1;
        shift_right = 1'b0;
        asr         = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) state_d = LOAD;
            end
            LOAD: begin
                load_n = 1'b0;
                asr    = arith_q;
                if (shamt_q != '0) begin
                    state_d = SHIFT;
                    cnt_d   = shamt_q;
                end else begin
                    state_d = CAPTURE;
                end
            end
            SHIFT: begin
                shift_right = 1'b1;
                asr         = arith_q;
                cnt_d       = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) state_d = CAPTURE;
            end
            CAPTURE: begin
                asr     = arith_q;
                state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shamt_q  <= '0;
            arith_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                shamt_q <= shamt;
                arith_q <= arith;
            end
            if (state_q == CAPTURE) result_q <= shift_in;
        end
    end

    assign result = result_q;

`ifdef SHIFT_SEQ_CHECK_EN
    logic [DATA_W-1:0] load_val_q;
    logic [DATA_W-1:0] exp_val;
    logic              mismatch_q;

    shift_seq_model u_model (
        .val_i   (load_val_q),
        .shamt_i (shamt_q),
        .arith_i (arith_q),
        .exp_o   (exp_val)
    );

    // Sticky until the next accepted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load_val_q <= '0;
            mismatch_q <= 1'b0;
        end else begin
            if (accept) begin
                load_val_q <= load_val;
                mismatch_q <= 1'b0;
            end else if (state_q == CAPTURE && shift_in != exp_val) begin
                mismatch_q <= 1'b1;
            end
        end
    end

    assign mismatch = mismatch_q;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with a behavioural load/shift shifter.
// Mismatch scenario expectations follow SHIFT_SEQ_CHECK_EN.
module tb_shift_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] load_val = 8'h00;
    logic [2:0] shamt = 3'd0;
    logic       arith = 1'b0;
    logic [7:0] shift_in;
    logic       load_n, shift_right, asr, busy, done, mismatch;
    logic [7:0] result;

    logic [7:0] sh_q = 8'h00;
    logic       force_zero = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .load_val    (load_val),
        .shamt       (shamt),
        .arith       (arith),
        .shift_in    (shift_in),
        .load_n      (load_n),
        .shift_right (shift_right),
        .asr         (asr),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .mismatch    (mismatch)
    );

    // Behavioural downstream shifter
    always @(posedge clk) begin
        if (!load_n)
            sh_q <= load_val;
        else if (shift_right)
            sh_q <= asr ? {sh_q[7], sh_q[7:1]} : {1'b0, sh_q[7:1]};
    end

    assign shift_in = force_zero ? 8'h00 : sh_q;

    // Runs one operation; scrambles inputs after acceptance.
    task automatic do_op(input logic [7:0] v, input logic [2:0] s,
                         input logic a, output int dcyc,
                         output logic [7:0] res, output int srn,
                         output int asn, output logic mm);
        dcyc = -1; res = 8'h00; srn = 0; asn = 0; mm = 1'b0;
        @(negedge clk);
        load_val = v; shamt = s; arith = a; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (shift_right) srn++;
            if (asr) asn++;
            if (c == 1) begin shamt = ~s; arith = ~a; end
            if (c == 2) load_val = ~v;
            if (done) begin
                dcyc = c; res = result; mm = mismatch;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (load_n !== 1'b1) begin errors++;
            $display("FAIL reset_load_n: got %b expected 1", load_n); end
        vectors++;
        if (shift_right !== 1'b0) begin errors++;
            $display("FAIL reset_shift_right: got %b expected 0", shift_right); end
        vectors++;
        if (asr !== 1'b0) begin errors++;
            $display("FAIL reset_asr: got %b expected 0", asr); end
        vectors++;
        if (busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++;
        if (done !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b expected 0", done); end
        vectors++;
        if (result !== 8'h00) begin errors++;
            $display("FAIL reset_result: got %h expected 00", result); end
        vectors++;
        if (mismatch !== 1'b0) begin errors++;
            $display("FAIL reset_mismatch: got %b expected 0", mismatch); end
        reset_n = 1'b1;
    endtask

    task automatic test_logical;
        int d, sr, as; logic [7:0] r; logic m;
        do_op(8'hB4, 3'd3, 1'b0, d, r, sr, as, m);
        vectors++;
        if (d !== 6) begin errors++;
            $display("FAIL lsr_done_cycle: got %0d expected 6", d); end
        vectors++;
        if (r !== 8'h16) begin errors++;
            $display("FAIL lsr_result: got %h expected 16", r); end
        vectors++;
        if (sr !== 3) begin errors++;
            $display("FAIL lsr_shift_cycles: got %0d expected 3", sr); end
        vectors++;
        if (as !== 0) begin errors++;
            $display("FAIL lsr_asr_cycles: got %0d expected 0", as); end
        vectors++;
        if (m !== 1'b0) begin errors++;
            $display("FAIL lsr_mismatch: got %b expected 0", m); end
    endtask

    task automatic test_arith;
        int d, sr, as; logic [7:0] r; logic m;
        do_op(8'hB4, 3'd3, 1'b1, d, r, sr, as, m);
        vectors++;
        if (r !== 8'hF6) begin errors++;
            $display("FAIL asr_result: got %h expected f6", r); end
        vectors++;
        if (as !== 5) begin errors++;
            $display("FAIL asr_cycles: got %0d expected 5", as); end
        vectors++;
        if (d !== 6) begin errors++;
            $display("FAIL asr_done_cycle: got %0d expected 6", d); end
    endtask

    task automatic test_zero_shift;
        int d, sr, as; logic [7:0] r; logic m;
        do_op(8'h5A, 3'd0, 1'b0, d, r, sr, as, m);
        vectors++;
        if (d !== 3) begin errors++;
            $display("FAIL zero_done_cycle: got %0d expected 3", d); end
        vectors++;
        if (sr !== 0) begin errors++;
            $display("FAIL zero_shift_cycles: got %0d expected 0", sr); end
        vectors++;
        if (r !== 8'h5A) begin errors++;
            $display("FAIL zero_result: got %h expected 5a", r); end
    endtask

    task automatic test_back_to_back;
        int dn, idle, bad;
        dn = 0; idle = 0; bad = 0;
        @(negedge clk);
        load_val = 8'h33; shamt = 3'd1; arith = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (done) begin
                dn++;
                if (result !== 8'h19) bad++;
            end
            if (!busy) idle++;
            if (busy !== ((c % 5) != 0)) bad++;
        end
        start = 1'b0;
        vectors++;
        if (dn !== 3) begin errors++;
            $display("FAIL b2b_done_count: got %0d expected 3", dn); end
        vectors++;
        if (idle !== 2) begin errors++;
            $display("FAIL b2b_idle_cycles: got %0d expected 2", idle); end
        vectors++;
        if (bad !== 0) begin errors++;
            $display("FAIL b2b_pattern: got %0d bad cycles expected 0", bad); end
    endtask

    task automatic test_reset_mid;
        int d, sr, as, dn; logic [7:0] r; logic m;
        @(negedge clk);
        load_val = 8'h5A; shamt = 3'd7; arith = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({busy, shift_right, asr} !== 3'b111) begin errors++;
            $display("FAIL mid_pre_shift: got %b expected 111",
                     {busy, shift_right, asr}); end
        reset_n = 1'b0;
        #1;
        vectors++;
        if ({busy, load_n, shift_right, asr, done, mismatch, result}
            !== {6'b010000, 8'h00}) begin errors++;
            $display("FAIL mid_reset_outputs: got %b expected 01000000000000",
                     {busy, load_n, shift_right, asr, done, mismatch, result});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dn++;
        end
        vectors++;
        if (dn !== 0) begin errors++;
            $display("FAIL mid_no_done: got %0d expected 0", dn); end
        do_op(8'h80, 3'd7, 1'b1, d, r, sr, as, m);
        vectors++;
        if (r !== 8'hFF) begin errors++;
            $display("FAIL post_reset_result: got %h expected ff", r); end
        vectors++;
        if (d !== 10) begin errors++;
            $display("FAIL post_reset_done_cycle: got %0d expected 10", d); end
        vectors++;
        if (as !== 9) begin errors++;
            $display("FAIL post_reset_asr_cycles: got %0d expected 9", as); end
    endtask

    task automatic test_check;
        int d, sr, as; logic [7:0] r; logic m;
        force_zero = 1'b1;
        do_op(8'hB4, 3'd3, 1'b0, d, r, sr, as, m);
        force_zero = 1'b0;
        vectors++;
        if (r !== 8'h00) begin errors++;
            $display("FAIL forced_result: got %h expected 00", r); end
        repeat (3) @(negedge clk);
`ifdef SHIFT_SEQ_CHECK_EN
        vectors++;
        if (m !== 1'b1) begin errors++;
            $display("FAIL check_mismatch_set: got %b expected 1", m); end
        vectors++;
        if (mismatch !== 1'b1) begin errors++;
            $display("FAIL check_mismatch_held: got %b expected 1", mismatch); end
        do_op(8'hB4, 3'd3, 1'b0, d, r, sr, as, m);
        vectors++;
        if (m !== 1'b0) begin errors++;
            $display("FAIL check_mismatch_clear: got %b expected 0", m); end
`else
        vectors++;
        if (m !== 1'b0) begin errors++;
            $display("FAIL nocheck_mismatch: got %b expected 0", m); end
        vectors++;
        if (mismatch !== 1'b0) begin errors++;
            $display("FAIL nocheck_mismatch_idle: got %b expected 0", mismatch); end
`endif
    endtask

    initial begin
        test_reset();
        test_logical();
        test_arith();
        test_zero_shift();
        test_back_to_back();
        test_reset_mid();
        test_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
- REQ-001: Module SHALL have no parameters; widths SHALL come from package constants DATA_W=8 and SHAMT_W=3.
- REQ-002: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: reset_n  input  1  asynchronous, active-low reset.
- REQ-004: start  input  1  request; SHALL be sampled only in IDLE.
- REQ-005: load_val  input  8  value to load into the downstream 8-bit shifter.
- REQ-006: shamt  input  3  shift count, 0..7.
- REQ-007: arith  input  1  1 = arithmetic (sign-extending) shift, 0 = logical shift.
- REQ-008: shift_in  input  8  parallel output of the shifter, fed back.
- REQ-009: load_n  output  1  shifter parallel-load control, active-low.
- REQ-010: shift_right  output  1  shifter shift-enable.
- REQ-011: asr  output  1  shifter arithmetic-shift select.
- REQ-012: busy  output  1  high in every state except IDLE.
- REQ-013: done  output  1  one-cycle pulse; result is valid while done is high.
- REQ-014: result  output  8  captured shifter value, held until the next capture.
- REQ-015: mismatch  output  1  self-check flag (see Configuration).

Function
- REQ-016: FSM states SHALL be IDLE, LOAD, SHIFT, CAPTURE and DONE.
- REQ-017: In IDLE with start=1, the block SHALL register load_val, shamt and arith, then go to LOAD.
- REQ-018: LOAD SHALL last one cycle with load_n=0 and shift_right=0.
- REQ-019: After LOAD, the FSM SHALL go to SHIFT if shamt_q>0, else to CAPTURE.
- REQ-020: SHIFT SHALL hold load_n=1 and shift_right=1 for exactly shamt_q cycles, counted by a 3-bit down-counter.
- REQ-021: CAPTURE SHALL last one cycle with shift_right=0 and load_n=1; result SHALL load shift_in at the end of that cycle.
- REQ-022: DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
- REQ-023: asr SHALL equal arith_q in LOAD, SHIFT and CAPTURE, and 0 in IDLE and DONE.
- REQ-024: Latency: with start sampled at edge E0, done SHALL be high in cycle shamt+3 after E0; for shamt=0 that is cycle 3.
- REQ-025: start SHALL be ignored in LOAD, SHIFT, CAPTURE and DONE; the earliest next acceptance is in the IDLE cycle after DONE.
- REQ-026: Changes to load_val, shamt or arith after acceptance SHALL NOT affect the operation in progress.
- REQ-027: In IDLE, load_n SHALL be 1 and shift_right SHALL be 0, so the shifter holds its value.

Reset
- REQ-028: reset_n=0 SHALL immediately force state=IDLE, load_n=1, shift_right=0, asr=0, busy=0, done=0, result=0x00, mismatch=0, counter=0 and the captured registers to 0.
- REQ-029: Reset asserted mid-operation SHALL abandon the operation with no done pulse.
- REQ-030: After reset deasserts, the first start SHALL be accepted normally.

Configuration
- REQ-031: With macro SHIFT_SEQ_CHECK_EN defined, at CAPTURE the block SHALL compare shift_in against the expected value: arith_q ? sign-extended load_val_q>>shamt_q : load_val_q>>shamt_q.
- REQ-032: With the macro defined, mismatch SHALL be set on inequality, held until the next accepted start, and cleared on that start.
- REQ-033: Without the macro, mismatch SHALL be tied to 0 and no comparison logic SHALL exist; the port list is identical in both builds.

Structure
- REQ-034: Package shift_seq_pkg SHALL hold DATA_W, SHAMT_W and the FSM state enum type.
- REQ-035: Sub-module shift_seq_model SHALL compute the expected value combinationally; it SHALL be instantiated only under SHIFT_SEQ_CHECK_EN.

Verification (bench pairs DUT with a behavioural 8-bit load/shift-right/ASR shifter)
- REQ-036: load_val=0xB4, shamt=3, arith=0 -> done in cycle 6, result=0x16, mismatch=0.
- REQ-037: load_val=0xB4, shamt=3, arith=1 -> result=0xF6, asr=1 for the 5 cycles LOAD..CAPTURE.
- REQ-038: load_val=0x5A, shamt=0 -> no shift_right cycle, done in cycle 3, result=0x5A.
- REQ-039: start held high through an entire operation -> exactly one done per IDLE acceptance, and busy drops for exactly one cycle between operations.
- REQ-040: reset_n pulsed low during the second SHIFT cycle of shamt=7 -> outputs at reset values immediately, no done, and the next op 0x80/shamt=7/arith=1 gives 0xFF.
- REQ-041: SHIFT_SEQ_CHECK_EN build with the shifter model forced to shift_in=0x00 at CAPTURE for 0xB4/3/0 -> mismatch=1 until the next start.
